rs232_rx_sram: RTL and testbench
================================

// Module: rs232_rx_sram
// PURPOSE
//  Receive-side companion to the RS232 frame sender: an Avalon-MM master that polls the UART status register.
//  Each received byte is read from the RX register and written to SRAM at incrementing addresses until TOTAL_ADDR bytes (one 320x240 8-bit frame) are stored.
//  Sits between the UART Avalon slave and the SRAM write arbiter; started by the top-level controller.
// PARAMETERS
//  TOTAL_ADDR   76800  bytes per frame (320*240); last SRAM address = TOTAL_ADDR-1
//  ADDR_W       17     SRAM address width; must hold TOTAL_ADDR-1
//  RX_BASE      0      UART RX data register byte address
//  STATUS_BASE  8      UART status register byte address
//  RX_OK_BIT    7      status bit set when an RX byte is available
// PORTS
//  avm_clk          in   1       single clock; all logic posedge
//  avm_rst          in   1       asynchronous, active-high reset
//  avm_address      out  5       Avalon address (RX_BASE or STATUS_BASE)
//  avm_read         out  1       Avalon read request
//  avm_readdata     in   32      Avalon read data
//  avm_write        out  1       Avalon write; tied 0
//  avm_writedata    out  32      tied 0
//  avm_waitrequest  in   1       slave stall; transfer completes when low
//  recv_start       in   1       level/pulse; accepted only in S_IDLE
//  recv_abort       in   1       abandon current frame (see BEHAVIOUR)
//  recv_finished    out  1       1 after full frame stored; sticky until next accepted start
//  sram_wr_addr     out  ADDR_W  SRAM byte address of current byte
//  sram_wr_data     out  8       received byte
//  sram_wr_req      out  1       SRAM write request; held until ack
//  sram_wr_ack      in   1       SRAM accepted write (sampled while req=1)
//  rs232_rx_state   out  4       state_r for debug/LEDs
// BEHAVIOUR
//  All outputs registered. Reset: avm_address=STATUS_BASE, avm_read=0, avm_write=0, recv_finished=0,
//   sram_wr_addr=0, sram_wr_data=0, sram_wr_req=0, state=S_IDLE, abort_pending=0. Reset mid-frame discards all progress.
//  States (rs232_rx_state encoding): S_IDLE=0, S_WAIT_RECV=1, S_READ_DATA=2, S_WRITE_SRAM=3.
//  S_IDLE: avm_read=0. On recv_start: next cycle S_WAIT_RECV, avm_read=1, avm_address=STATUS_BASE,
//   recv_finished=0, sram_wr_addr=0.
//  S_WAIT_RECV: keep read of STATUS_BASE. On !waitrequest && readdata[RX_OK_BIT]=1: S_READ_DATA, address=RX_BASE, read stays 1.
//   On !waitrequest && bit=0: stay, re-poll back-to-back.
//  S_READ_DATA: on !waitrequest: sram_wr_data<=readdata[7:0], avm_read=0, sram_wr_req=1, S_WRITE_SRAM.
//  S_WRITE_SRAM: req/addr/data stable until sram_wr_ack. On ack: req=0.
//   If sram_wr_addr==TOTAL_ADDR-1: S_IDLE, sram_wr_addr=0, recv_finished=1.
//   Otherwise: sram_wr_addr+1, S_WAIT_RECV, read STATUS_BASE.
//  Avalon rule: avm_address/avm_read never change while avm_read=1 && avm_waitrequest=1.
//  recv_abort: ignored in S_IDLE. Otherwise sets abort_pending; taken at the next transfer completion
//   (!waitrequest in WAIT/READ, ack in WRITE). Then: S_IDLE, avm_read=0, req=0, sram_wr_addr=0,
//   recv_finished=0, abort_pending=0. A data byte read under abort is dropped.
//  Abort coinciding with last-byte ack: completion wins (recv_finished=1).
//  recv_start outside S_IDLE ignored. recv_start with recv_finished=1 restarts and clears it.
//  Min per byte: 1 status cycle + 1 RX read cycle + 1 write cycle (+ ack latency).
// TESTING
//  1 Assert avm_rst mid-S_WRITE_SRAM -> req=0, read=0, addr=STATUS_BASE, state=0 same cycle (async).
//  2 TOTAL_ADDR=4; start; status bit7=0 twice then 1; RX=0x5A -> wr_data=0x5A, addr=0, req held till ack.
//  3 waitrequest=1 for 3 cycles on each read -> avm_address/avm_read stable throughout; no early advance.
//  4 TOTAL_ADDR=4; bytes 0x11,0x22,0x33,0x44 -> writes to addrs 0..3; recv_finished=1 after 4th ack; addr=0; state=0.
//  5 Abort after byte 1 ack, mid S_READ_DATA -> byte dropped, state 0, finished=0; restart stores from addr 0.
//  6 Abort on same cycle as last ack -> recv_finished=1; recv_start while busy -> ignored, no address reset.

Source files
------------

// File: rtl/rs232_rx_sram.sv
// rs232_rx_sram
//   Avalon-MM master that polls a UART for received bytes and writes each one
//   into SRAM at incrementing byte addresses, until one full frame of
//   TOTAL_ADDR bytes has been stored.
//
//   Handshakes:
//     Avalon read: an access completes on a cycle where avm_read=1 and
//     avm_waitrequest=0. avm_address/avm_read hold steady while stalled.
//     SRAM write: sram_wr_req is held, with addr/data stable, until
//     sram_wr_ack is seen high. ack is only looked at while req is high.
//
//   Ports:
//     avm_clk, avm_rst             clock, asynchronous active-high reset
//     avm_address/read/readdata    UART register reads (status, RX data)
//     avm_write/writedata          unused write path, tied low
//     avm_waitrequest              slave stall
//     recv_start/recv_abort        frame control from the top-level controller
//     recv_finished                sticky "frame stored" flag
//     sram_wr_addr/data/req/ack    write port toward the SRAM arbiter
//     rs232_rx_state               current FSM state for debug/LEDs
module rs232_rx_sram #(
  parameter int         TOTAL_ADDR  = 76800,
  parameter int         ADDR_W      = 17,
  parameter logic [4:0] RX_BASE     = 5'd0,
  parameter logic [4:0] STATUS_BASE = 5'd8,
  parameter int         RX_OK_BIT   = 7
) (
  input  logic              avm_clk,
  input  logic              avm_rst,
  output logic [4:0]        avm_address,
  output logic              avm_read,
  input  logic [31:0]       avm_readdata,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic              recv_start,
  input  logic              recv_abort,
  output logic              recv_finished,
  output logic [ADDR_W-1:0] sram_wr_addr,
  output logic [7:0]        sram_wr_data,
  output logic              sram_wr_req,
  input  logic              sram_wr_ack,
  output logic [3:0]        rs232_rx_state
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_WAIT_RECV  = 4'd1,
    S_READ_DATA  = 4'd2,
    S_WRITE_SRAM = 4'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL_ADDR - 1);

  state_t            state_r, state_n;
  logic [4:0]        address_r, address_n;
  logic              read_r, read_n;
  logic              finished_r, finished_n;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_n;
  logic [7:0]        wr_data_r, wr_data_n;
  logic              wr_req_r, wr_req_n;
  logic              abort_pending_r, abort_pending_n;
  logic              xfer_done;
  logic              abort_now;
  logic              take_abort;
  logic              unused_readdata;

  // Only the low byte and the status flag are consumed.
  assign unused_readdata = ^avm_readdata[31:8];

  assign xfer_done = read_r & ~avm_waitrequest;
  // An abort raised on the very cycle a transfer completes is honoured there.
  assign abort_now = abort_pending_r | recv_abort;

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state_r         <= S_IDLE;
      address_r       <= STATUS_BASE;
      read_r          <= 1'b0;
      finished_r      <= 1'b0;
      wr_addr_r       <= '0;
      wr_data_r       <= '0;
      wr_req_r        <= 1'b0;
      abort_pending_r <= 1'b0;
    end else begin
      state_r         <= state_n;
      address_r       <= address_n;
      read_r          <= read_n;
      finished_r      <= finished_n;
      wr_addr_r       <= wr_addr_n;
      wr_data_r       <= wr_data_n;
      wr_req_r        <= wr_req_n;
      abort_pending_r <= abort_pending_n;
    end
  end

  always_comb begin
    state_n         = state_r;
    address_n       = address_r;
    read_n          = read_r;
    finished_n      = finished_r;
    wr_addr_n       = wr_addr_r;
    wr_data_n       = wr_data_r;
    wr_req_n        = wr_req_r;
    abort_pending_n = abort_pending_r;
    take_abort      = 1'b0;

    if (state_r != S_IDLE && recv_abort) abort_pending_n = 1'b1;

    case (state_r)
      S_IDLE: begin
        read_n = 1'b0;
        if (recv_start) begin
          state_n    = S_WAIT_RECV;
          read_n     = 1'b1;
          address_n  = STATUS_BASE;
          finished_n = 1'b0;
          wr_addr_n  = '0;
        end
      end
      S_WAIT_RECV: begin
        if (xfer_done) begin
          if (abort_now) begin
            take_abort = 1'b1;
          end else if (avm_readdata[RX_OK_BIT]) begin
            state_n   = S_READ_DATA;
            address_n = RX_BASE;
          end
          // flag clear: keep polling status with read held high
        end
      end
      S_READ_DATA: begin
        if (xfer_done) begin
          if (abort_now) begin
            take_abort = 1'b1;  // byte is dropped
          end else begin
            wr_data_n = avm_readdata[7:0];
            read_n    = 1'b0;
            wr_req_n  = 1'b1;
            state_n   = S_WRITE_SRAM;
          end
        end
      end
      S_WRITE_SRAM: begin
        if (sram_wr_ack) begin
          wr_req_n = 1'b0;
          // Finishing the last byte takes priority over a pending abort.
          if (wr_addr_r == LAST_ADDR) begin
            state_n         = S_IDLE;
            wr_addr_n       = '0;
            finished_n      = 1'b1;
            abort_pending_n = 1'b0;
            address_n       = STATUS_BASE;
          end else if (abort_now) begin
            take_abort = 1'b1;
          end else begin
            wr_addr_n = wr_addr_r + 1'b1;
            state_n   = S_WAIT_RECV;
            read_n    = 1'b1;
            address_n = STATUS_BASE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (take_abort) begin
      state_n         = S_IDLE;
      read_n          = 1'b0;
      wr_req_n        = 1'b0;
      wr_addr_n       = '0;
      finished_n      = 1'b0;
      abort_pending_n = 1'b0;
      address_n       = STATUS_BASE;
    end
  end

  assign avm_address    = address_r;
  assign avm_read       = read_r;
  assign avm_write      = 1'b0;
  assign avm_writedata  = '0;
  assign recv_finished  = finished_r;
  assign sram_wr_addr   = wr_addr_r;
  assign sram_wr_data   = wr_data_r;
  assign sram_wr_req    = wr_req_r;
  assign rs232_rx_state = state_r;

endmodule

// File: tb/tb_rs232_rx_sram.sv
module tb_rs232_rx_sram;

  localparam int         TOTAL    = 4;
  localparam int         AW       = 17;
  localparam logic [4:0] RX_A     = 5'd0;
  localparam logic [4:0] STATUS_A = 5'd8;
  localparam int         BUDGET   = 3000;

  // ---------------- clock / reset / DUT ----------------
  logic          avm_clk = 1'b0;
  logic          avm_rst;
  logic [4:0]    avm_address;
  logic          avm_read;
  logic [31:0]   avm_readdata;
  logic          avm_write;
  logic [31:0]   avm_writedata;
  logic          avm_waitrequest;
  logic          recv_start;
  logic          recv_abort;
  logic          recv_finished;
  logic [AW-1:0] sram_wr_addr;
  logic [7:0]    sram_wr_data;
  logic          sram_wr_req;
  logic          sram_wr_ack;
  logic [3:0]    rs232_rx_state;

  always #5 avm_clk = ~avm_clk;

  rs232_rx_sram #(.TOTAL_ADDR(TOTAL), .ADDR_W(AW)) dut (
    .avm_clk(avm_clk), .avm_rst(avm_rst),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest),
    .recv_start(recv_start), .recv_abort(recv_abort), .recv_finished(recv_finished),
    .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
    .sram_wr_req(sram_wr_req), .sram_wr_ack(sram_wr_ack),
    .rs232_rx_state(rs232_rx_state)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Frame rules: bytes delivered by completed RX reads are written in
  // order to addresses 0,1,2..; a frame ends after TOTAL writes, or at the
  // first completed transfer once an abort has been requested (a byte read
  // under abort is never written).
  logic [7:0] exp_q[$];
  logic [7:0] wr_log[TOTAL];
  bit         m_busy, m_fin, m_abort_pend, m_expect_rx;
  int         exp_addr, n_writes, n_dropped;

  // slave behaviour knobs
  bit         stall_mode, hold_ack, force_ack;
  int         wait_cnt;
  bit         stat_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] cur_rx;
  bit         rx_valid;

  // previous-cycle snapshot (values the DUT saw at the last posedge)
  bit          s_valid, s_read, s_wait, s_req, s_ack, s_start, s_abort;
  logic [4:0]  s_addr;
  logic [31:0] s_rdata;
  logic [AW-1:0] s_wr_addr;
  logic [7:0]  s_wr_data;

  initial begin
    bit          ab;
    bit          sbit;
    logic [31:0] w;
    avm_waitrequest = 1'b0;
    avm_readdata    = '0;
    sram_wr_ack     = 1'b0;
    s_valid         = 1'b0;
    forever begin
      @(negedge avm_clk);
      if (avm_rst) begin
        m_busy = 0; m_fin = 0; m_abort_pend = 0; m_expect_rx = 0;
        exp_addr = 0; exp_q.delete();
        s_valid = 0; rx_valid = 0; wait_cnt = 0;
        avm_waitrequest = 1'b0; sram_wr_ack = 1'b0;
      end else begin
        // consume what the slave handed over last cycle
        if (s_valid && s_read && !s_wait) begin
          wait_cnt = 0;
          if (s_addr == STATUS_A) begin
            if (stat_q.size() > 0) void'(stat_q.pop_front());
          end else begin
            rx_valid = 0;
          end
        end
        // model update
        if (s_valid) begin
          if (!m_busy) begin
            if (s_start) begin
              m_busy = 1; m_fin = 0; m_abort_pend = 0; m_expect_rx = 0;
              exp_addr = 0; n_writes = 0; n_dropped = 0;
            end
          end else begin
            ab = m_abort_pend || s_abort;
            m_abort_pend = ab;
            if (s_read && !s_wait) begin
              check("rd_addr", s_addr, m_expect_rx ? RX_A : STATUS_A);
              if (ab) begin
                if (s_addr == RX_A) n_dropped++;
                m_busy = 0; m_fin = 0; m_abort_pend = 0;
              end else if (s_addr == STATUS_A) begin
                m_expect_rx = s_rdata[7];
              end else begin
                exp_q.push_back(s_rdata[7:0]);
                m_expect_rx = 0;
              end
            end
            if (s_req && s_ack) begin
              check("wr_addr", s_wr_addr, exp_addr);
              check("wr_q_depth", exp_q.size(), 1);
              if (exp_q.size() > 0) check("wr_data", s_wr_data, exp_q.pop_front());
              if (s_wr_addr < TOTAL) wr_log[s_wr_addr] = s_wr_data;
              n_writes++;
              if (exp_addr == TOTAL - 1) begin
                m_busy = 0; m_fin = 1; m_abort_pend = 0;
              end else if (ab) begin
                m_busy = 0; m_fin = 0; m_abort_pend = 0;
              end else begin
                exp_addr++;
              end
            end
          end
          // protocol holds
          if (s_read && s_wait) begin
            check("rd_hold", avm_read, 1);
            check("addr_hold", avm_address, s_addr);
          end
          if (s_req && !s_ack) begin
            check("req_hold", sram_wr_req, 1);
            check("wraddr_hold", sram_wr_addr, s_wr_addr);
            check("wrdata_hold", sram_wr_data, s_wr_data);
          end
          check("busy", rs232_rx_state != 4'd0, m_busy);
          check("fin_track", recv_finished, m_fin);
        end
        // drive slave for the coming posedge
        if (avm_read) begin
          if (stall_mode) begin
            avm_waitrequest = (wait_cnt < 3);
            wait_cnt++;
          end else begin
            avm_waitrequest = ($urandom_range(0, 3) == 0);
          end
          w = $urandom;
          if (avm_address == STATUS_A) begin
            sbit = (stat_q.size() > 0) ? stat_q[0] : ($urandom_range(0, 2) == 0);
            w[7] = sbit;
          end else begin
            if (!rx_valid) begin
              cur_rx   = (rx_q.size() > 0) ? rx_q.pop_front() : 8'($urandom_range(0, 255));
              rx_valid = 1;
            end
            w[7:0] = cur_rx;
          end
          avm_readdata = w;
        end else begin
          avm_waitrequest = $urandom_range(0, 1);
          avm_readdata    = $urandom;
        end
        if (sram_wr_req) begin
          if (force_ack)     sram_wr_ack = 1'b1;
          else if (hold_ack) sram_wr_ack = 1'b0;
          else               sram_wr_ack = ($urandom_range(0, 2) == 0);
        end else begin
          sram_wr_ack = 1'b0;
        end
        // snapshot
        s_valid   = 1;
        s_read    = avm_read;
        s_wait    = avm_waitrequest;
        s_addr    = avm_address;
        s_rdata   = avm_readdata;
        s_req     = sram_wr_req;
        s_ack     = sram_wr_ack;
        s_wr_addr = sram_wr_addr;
        s_wr_data = sram_wr_data;
        s_start   = recv_start;
        s_abort   = recv_abort;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame();
    @(posedge avm_clk); #1 recv_start = 1'b1;
    @(posedge avm_clk); #1 recv_start = 1'b0;
  endtask

  // Runs until the DUT is idle; optionally glitches recv_start while busy.
  task automatic wait_idle(input string tag, input bit glitch);
    int n = 0;
    do begin
      @(posedge avm_clk); #1;
      n++;
      recv_start = glitch && (rs232_rx_state != 4'd0) && ($urandom_range(0, 7) == 0);
    end while (rs232_rx_state != 4'd0 && n < BUDGET);
    recv_start = 1'b0;
    check({tag, "_idle"}, rs232_rx_state, 4'd0);
    @(negedge avm_clk); #1;
  endtask

  task automatic wait_state(input string tag, input logic [3:0] st, input int min_writes);
    int n = 0;
    do begin
      @(posedge avm_clk); #1;
      n++;
    end while (!(rs232_rx_state == st && n_writes >= min_writes) && n < BUDGET);
    check({tag, "_reach"}, rs232_rx_state, st);
  endtask

  task automatic check_full_frame(input string tag);
    check({tag, "_fin"}, recv_finished, 1);
    check({tag, "_nwr"}, n_writes, TOTAL);
    check({tag, "_addr0"}, sram_wr_addr, 0);
    check({tag, "_req"}, sram_wr_req, 0);
    check({tag, "_rd"}, avm_read, 0);
    check({tag, "_q"}, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    avm_rst = 1'b1; recv_start = 1'b0; recv_abort = 1'b0;
    stall_mode = 0; hold_ack = 0; force_ack = 0; n_writes = 0; n_dropped = 0;
    repeat (3) @(posedge avm_clk);
    #1;
    check("rst_addr", avm_address, STATUS_A);
    check("rst_read", avm_read, 0);
    check("rst_write", avm_write, 0);
    check("rst_wdata", avm_writedata, 0);
    check("rst_fin", recv_finished, 0);
    check("rst_wraddr", sram_wr_addr, 0);
    check("rst_wrdata", sram_wr_data, 0);
    check("rst_req", sram_wr_req, 0);
    check("rst_state", rs232_rx_state, 0);
    avm_rst = 1'b0;
    repeat (2) @(posedge avm_clk);

    // status flag clear twice then set; 0x5A first; 3-cycle stalls on reads
    stat_q = '{1'b0, 1'b0, 1'b1};
    rx_q   = '{8'h5A};
    stall_mode = 1; hold_ack = 1;
    start_frame();
    n = 0;
    do begin @(posedge avm_clk); #1; n++; end while (!sram_wr_req && n < BUDGET);
    check("b1_req", sram_wr_req, 1);
    check("b1_data", sram_wr_data, 8'h5A);
    check("b1_addr", sram_wr_addr, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge avm_clk); #1;
      check("b1_req_held", sram_wr_req, 1);
    end
    hold_ack = 0;
    wait_idle("stall", 0);
    check_full_frame("stall");
    stall_mode = 0;

    // four known bytes
    rx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    start_frame();
    wait_idle("four", 0);
    check_full_frame("four");
    check("four_b0", wr_log[0], 8'h11);
    check("four_b1", wr_log[1], 8'h22);
    check("four_b2", wr_log[2], 8'h33);
    check("four_b3", wr_log[3], 8'h44);

    // abort while reading the second byte
    start_frame();
    check("restart_fin_clr", recv_finished, 0);
    wait_state("abort", 4'd2, 1);
    recv_abort = 1'b1;
    @(posedge avm_clk); #1 recv_abort = 1'b0;
    wait_idle("abort", 0);
    check("abort_fin", recv_finished, 0);
    check("abort_nwr", n_writes, 1);
    check("abort_drop", n_dropped, 1);
    check("abort_q", exp_q.size(), 0);
    check("abort_addr0", sram_wr_addr, 0);
    start_frame();
    wait_idle("after_abort", 1);
    check_full_frame("after_abort");

    // abort on the same cycle as the last ack, with stray starts while busy
    start_frame();
    repeat (2) @(posedge avm_clk);
    #1 recv_start = 1'b1;
    @(posedge avm_clk); #1 recv_start = 1'b0;
    n = 0;
    do begin @(posedge avm_clk); #1; n++; end
    while (!(sram_wr_req && sram_wr_addr == AW'(TOTAL - 1)) && n < BUDGET);
    check("last_req", sram_wr_req, 1);
    recv_abort = 1'b1; force_ack = 1;
    @(posedge avm_clk); #1 recv_abort = 1'b0; force_ack = 0;
    wait_idle("last_abort", 0);
    check_full_frame("last_abort");

    // random frames with stray starts
    for (int f = 0; f < 4; f++) begin
      stall_mode = ($urandom_range(0, 3) == 0);
      start_frame();
      wait_idle("rand", 1);
      check_full_frame("rand");
    end
    stall_mode = 0;

    // asynchronous reset while a write is pending
    hold_ack = 1;
    start_frame();
    wait_state("rstw", 4'd3, 0);
    #2 avm_rst = 1'b1;
    #1;
    check("arst_req", sram_wr_req, 0);
    check("arst_read", avm_read, 0);
    check("arst_addr", avm_address, STATUS_A);
    check("arst_state", rs232_rx_state, 0);
    check("arst_wraddr", sram_wr_addr, 0);
    @(posedge avm_clk); #1 avm_rst = 1'b0;
    hold_ack = 0;
    repeat (2) @(posedge avm_clk);
    start_frame();
    wait_idle("post_rst", 1);
    check_full_frame("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
